cascade_divider: RTL and testbench

//  Chain of STAGES modulo counters with ripple carry. Each stage has its own run-time modulus.
//  The chain counts up or down, supports parallel load, and flags terminal count per stage.

---
 rtl/cascade_divider.sv | 75 +++++++
 tb/tb_cascade_divider.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_divider.sv
// Cascade of STAGES run-time-modulus counters with a single-cycle ripple carry.
// Counts up or down, loads in parallel, and flags terminal count per stage.
module cascade_divider #(
  parameter int STAGES = 3,
  parameter int W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  dir,
  input  logic                  load,
  input  logic [STAGES*W-1:0]   load_val,
  input  logic [STAGES*W-1:0]   mod_val,
  output logic [STAGES*W-1:0]   count,
  output logic [STAGES-1:0]     tc,
  output logic                  wrap
);

  logic [STAGES-1:0][W-1:0] cnt_p0;
  logic [STAGES-1:0][W-1:0] nxt;
  logic [STAGES-1:0]        adv;

  // A modulus of 0 or 1 makes the stage a permanent pass-through; out-of-range counts are terminal.
  function automatic logic stage_term(input logic [W-1:0] c, input logic [W-1:0] m,
                                      input logic up);
    logic t;
    if (m <= W'(1))  t = 1'b1;
    else if (c >= m) t = 1'b1;
    else if (up)     t = (c == m - W'(1));
    else             t = (c == '0);
    return t;
  endfunction

  function automatic logic [W-1:0] stage_next(input logic [W-1:0] c, input logic [W-1:0] m,
                                              input logic up, input logic term);
    logic [W-1:0] n;
    if (m <= W'(1)) n = '0;
    else if (term)  n = up ? '0 : m - W'(1);
    else            n = up ? c + W'(1) : c - W'(1);
    return n;
  endfunction

  // Carry ripples through every stage within the cycle; rst/load kill it at the source.
  always_comb begin
    logic carry;
    logic t;
    carry = ena & ~rst & ~load;
    adv   = '0;
    tc    = '0;
    nxt   = '0;
    for (int i = 0; i < STAGES; i++) begin
      t      = stage_term(cnt_p0[i], mod_val[i*W +: W], dir);
      adv[i] = carry;
      tc[i]  = carry & t;
      nxt[i] = stage_next(cnt_p0[i], mod_val[i*W +: W], dir, t);
      carry  = tc[i];
    end
  end

  // Stage register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= load_val;
    end else begin
      for (int i = 0; i < STAGES; i++)
        if (adv[i]) cnt_p0[i] <= nxt[i];
    end
  end

  assign count = cnt_p0;
  assign wrap  = tc[STAGES-1];

endmodule

// File: tb/tb_cascade_divider.sv
// Self-checking bench for cascade_divider (STAGES=3, W=4): directed scenarios plus
// randomized traffic against a plain-integer behavioural model.
module tb_cascade_divider;

  logic        clk = 1'b0;
  logic        rst, ena, dir, load;
  logic [11:0] load_val, mod_val;
  logic [11:0] count;
  logic [2:0]  tc;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  int       m_cnt[3] = '{0, 0, 0};
  int       m_nx[3];
  bit [2:0] m_tc;

  cascade_divider #(.STAGES(3), .W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir), .load(load),
    .load_val(load_val), .mod_val(mod_val),
    .count(count), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Mixed-radix digits of value v for stage moduli m0 (least significant) and m1.
  function automatic logic [11:0] dig(input int v, input int m0, input int m1);
    return {4'(v / (m0 * m1)), 4'((v / m0) % m1), 4'(v % m0)};
  endfunction

  function automatic logic [11:0] pk();
    return {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};
  endfunction

  // Behavioural model: what the chain should flag this cycle and hold after the next edge.
  function automatic void model_comb();
    bit carry;
    bit t;
    int m, c;
    carry = ena && !rst && !load;
    for (int i = 0; i < 3; i++) begin
      m = int'(mod_val[i*4 +: 4]);
      c = m_cnt[i];
      if (m <= 1)   t = 1;
      else if (dir) t = (c >= m - 1);
      else          t = (c == 0) || (c >= m);
      m_tc[i] = carry && t;
      m_nx[i] = c;
      if (carry) begin
        if (m <= 1)   m_nx[i] = 0;
        else if (dir) m_nx[i] = t ? 0 : c + 1;
        else          m_nx[i] = t ? m - 1 : c - 1;
      end
      carry = m_tc[i];
    end
    if (rst)       m_nx = '{0, 0, 0};
    else if (load) for (int i = 0; i < 3; i++) m_nx[i] = int'(load_val[i*4 +: 4]);
  endfunction

  task automatic test_reset();
    rst = 1; load = 0; ena = 1; dir = 1; load_val = 12'h000; mod_val = 12'hA6A;
    #1;
    checks++;
    if (tc !== 3'b000 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_tc: tc=%b wrap=%b expected 000/0", tc, wrap);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 12'h000) begin
      errors++; $display("FAIL reset_count: got %h expected 000", count);
    end
    rst = 0;
    m_cnt = '{0, 0, 0};
  endtask

  task automatic test_up_count();
    mod_val = 12'hA6A; dir = 1; ena = 1; load = 0; rst = 0;
    for (int k = 0; k < 600; k++) begin
      #1;
      checks++;
      if (count !== dig(k, 10, 6) || wrap !== (k == 599) || tc[0] !== (k % 10 == 9)) begin
        errors++;
        $display("FAIL up_count k=%0d: count=%h wrap=%b tc0=%b expected %h/%b/%b",
                 k, count, wrap, tc[0], dig(k, 10, 6), k == 599, k % 10 == 9);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (count !== 12'h000) begin
      errors++; $display("FAIL up_rollover: got %h expected 000", count);
    end
    m_cnt = '{0, 0, 0};
  endtask

  task automatic test_down();
    mod_val = 12'hA6A; dir = 0; ena = 1; load = 1; load_val = 12'h000;
    #1;
    checks++;
    if (tc !== 3'b000 || wrap !== 1'b0) begin
      errors++; $display("FAIL down_load_tc: tc=%b wrap=%b expected 000/0", tc, wrap);
    end
    @(posedge clk); #1;
    load = 0;
    m_cnt = '{0, 0, 0};
    #1;
    checks++;
    if (wrap !== 1'b1 || tc !== 3'b111) begin
      errors++; $display("FAIL down_wrap: tc=%b wrap=%b expected 111/1", tc, wrap);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 12'h959) begin
      errors++; $display("FAIL down_first: got %h expected 959", count);
    end
    m_cnt = '{9, 5, 9};
    for (int k = 0; k < 130; k++) begin
      #1;
      model_comb();
      checks++;
      if (tc[1] !== (m_cnt[0] == 0 && m_cnt[1] == 0) || tc !== m_tc) begin
        errors++; $display("FAIL down_tc k=%0d: tc=%b expected %b", k, tc, m_tc);
      end
      @(posedge clk); #1;
      m_cnt = m_nx;
      checks++;
      if (count !== pk()) begin
        errors++; $display("FAIL down_count k=%0d: got %h expected %h", k, count, pk());
      end
    end
  endtask

  task automatic test_ena_gap();
    int e = 0;
    int pulses = 0;
    mod_val = 12'h223; dir = 1; ena = 0; load = 1; load_val = 12'h000;
    @(posedge clk); #1;
    load = 0;
    for (int k = 0; k < 96; k++) begin
      ena = (k % 4 == 0);
      #1;
      if (wrap) pulses++;
      checks++;
      if (wrap !== (ena && e % 12 == 11)) begin
        errors++; $display("FAIL gap_wrap k=%0d: got %b expected %b", k, wrap, ena && e % 12 == 11);
      end
      @(posedge clk); #1;
      if (ena) e++;
      checks++;
      if (count !== dig(e % 12, 3, 2)) begin
        errors++; $display("FAIL gap_count k=%0d: got %h expected %h", k, count, dig(e % 12, 3, 2));
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL gap_pulses: got %0d expected 2", pulses);
    end
    ena = 0;
  endtask

  task automatic test_mod_change();
    for (int d = 1; d >= 0; d--) begin
      mod_val = 12'hA6A; dir = 1'(d); ena = 0; load = 1; load_val = 12'h327;
      @(posedge clk); #1;
      load = 0; ena = 1; mod_val = 12'hA65;
      #1;
      checks++;
      if (tc[0] !== 1'b1 || tc[1] !== 1'b0) begin
        errors++; $display("FAIL modchg_tc dir=%0d: tc=%b expected x01", d, tc);
      end
      @(posedge clk); #1;
      checks++;
      if (count !== (d ? 12'h330 : 12'h314)) begin
        errors++; $display("FAIL modchg_count dir=%0d: got %h expected %h", d, count, d ? 12'h330 : 12'h314);
      end
    end
    ena = 0;
  endtask

  task automatic test_degenerate();
    for (int mz = 0; mz < 2; mz++) begin
      mod_val = {8'hA6, 4'(mz)}; ena = 0; load = 1; load_val = 12'h000;
      #1; model_comb();
      @(posedge clk); #1;
      m_cnt = m_nx;
      load = 0;
      for (int k = 0; k < 24; k++) begin
        ena = ($urandom_range(0, 3) != 0);
        dir = 1'($urandom_range(0, 1));
        #1;
        model_comb();
        checks++;
        if (tc[0] !== ena || tc !== m_tc) begin
          errors++; $display("FAIL degen_tc m=%0d k=%0d: tc=%b expected %b", mz, k, tc, m_tc);
        end
        @(posedge clk); #1;
        m_cnt = m_nx;
        checks++;
        if (count !== pk() || count[3:0] !== 4'h0) begin
          errors++; $display("FAIL degen_count m=%0d k=%0d: got %h expected %h", mz, k, count, pk());
        end
      end
    end
    ena = 0;
  endtask

  task automatic test_rst_load();
    mod_val = 12'hA6A; dir = 1; ena = 0; load = 1; load_val = 12'h959;
    @(posedge clk); #1;
    load = 0; rst = 1; ena = 1;
    load = 1;
    #1;
    checks++;
    if (tc !== 3'b000 || wrap !== 1'b0) begin
      errors++; $display("FAIL rstload_tc: tc=%b wrap=%b expected 000/0", tc, wrap);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 12'h000) begin
      errors++; $display("FAIL rstload_count: got %h expected 000", count);
    end
    rst = 0; load = 1; load_val = 12'h959;
    #1;
    checks++;
    if (tc !== 3'b000 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_tc: tc=%b wrap=%b expected 000/0", tc, wrap);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 12'h959) begin
      errors++; $display("FAIL load_count: got %h expected 959", count);
    end
    load = 0;
    #1;
    checks++;
    if (tc !== 3'b111 || wrap !== 1'b1) begin
      errors++; $display("FAIL term_tc: tc=%b wrap=%b expected 111/1", tc, wrap);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 12'h000) begin
      errors++; $display("FAIL term_count: got %h expected 000", count);
    end
    ena = 0;
    m_cnt = '{0, 0, 0};
  endtask

  task automatic test_random();
    mod_val = 12'($urandom);
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 24) == 0);
      ena      = ($urandom_range(0, 4) != 0);
      dir      = (k % 100 < 50) ? 1'b1 : 1'($urandom_range(0, 1));
      load_val = 12'($urandom);
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 29) == 0) mod_val[i*4 +: 4] = 4'($urandom);
      #1;
      model_comb();
      checks++;
      if (tc !== m_tc || wrap !== m_tc[2]) begin
        errors++; $display("FAIL rand_tc k=%0d: tc=%b wrap=%b expected %b", k, tc, wrap, m_tc);
      end
      @(posedge clk); #1;
      m_cnt = m_nx;
      checks++;
      if (count !== pk()) begin
        errors++; $display("FAIL rand_count k=%0d: got %h expected %h", k, count, pk());
      end
    end
    rst = 0; load = 0; ena = 0;
  endtask

  initial begin
    rst = 1; ena = 0; dir = 1; load = 0; load_val = '0; mod_val = '0;
    #1;
    test_reset();
    test_up_count();
    test_down();
    test_ena_gap();
    test_mod_change();
    test_degenerate();
    test_rst_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
